// File: rtl/smem_bck_stage1_ctrl_p_if.sv
// Handshake and data bundle of the SMEM backward-extension stage-1 controller.
// master drives the token and downstream ready; slave is the controller.
interface smem_bck_stage1_ctrl_p_if #(
    parameter int RN_W = 6,
    parameter int AW   = 7,
    parameter int IW   = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_status;
    logic [RN_W-1:0] in_read_num;
    logic [AW-1:0]   in_bx;
    logic [7:0]      in_c;
    logic            in_iter_bnd;
    logic [AW-1:0]   in_bi;
    logic [AW-1:0]   in_bj;
    logic [AW-1:0]   in_new_size;
    logic [AW-1:0]   in_new_last_size;
    logic [AW-1:0]   in_fwd_size;
    logic [AW-1:0]   in_mem_wr_addr;
    logic [AW-1:0]   in_cur_wr_addr;
    logic [AW-1:0]   in_cur_rd_addr;
    logic [AW-1:0]   in_min_intv;
    logic [IW-1:0]   in_tok_x0;
    logic [IW-1:0]   in_tok_x1;
    logic [IW-1:0]   in_tok_x2;
    logic [IW-1:0]   in_p_x0;
    logic [IW-1:0]   in_p_x1;
    logic [IW-1:0]   in_p_x2;
    logic [63:0]     in_p_info;
    logic [IW-1:0]   in_last_x2;
    logic [31:0]     in_last_mem_info;

    logic            out_valid;
    logic            out_ready;
    logic [RN_W-1:0] out_read_num;
    logic [5:0]      out_status;
    logic [AW-1:0]   out_bi;
    logic [AW-1:0]   out_bj;
    logic [AW-1:0]   out_new_size;
    logic [AW-1:0]   out_new_last_size;
    logic [AW-1:0]   out_fwd_size;
    logic [AW-1:0]   out_mem_wr_addr;
    logic [AW-1:0]   out_cur_wr_addr;
    logic [AW-1:0]   out_cur_rd_addr;
    logic [AW-1:0]   out_min_intv;
    logic            out_iter_bnd;
    logic [7:0]      out_c;
    logic [IW-1:0]   out_resv_x2;
    logic [31:0]     out_resv_mem_info;
    logic            out_last_one;

    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [IW-1:0]   mem_x0;
    logic [IW-1:0]   mem_x1;
    logic [IW-1:0]   mem_x2;
    logic [63:0]     mem_info;
    logic            cur_we;
    logic [AW-1:0]   cur_addr;
    logic [IW-1:0]   cur_x0;
    logic [IW-1:0]   cur_x1;
    logic [IW-1:0]   cur_x2;
    logic [63:0]     cur_info;
    logic            err_mem_ovf;
    logic            err_cur_unf;

    modport master (
        output in_valid, in_status, in_read_num, in_bx, in_c, in_iter_bnd, in_bi, in_bj,
               in_new_size, in_new_last_size, in_fwd_size, in_mem_wr_addr, in_cur_wr_addr,
               in_cur_rd_addr, in_min_intv, in_tok_x0, in_tok_x1, in_tok_x2, in_p_x0, in_p_x1,
               in_p_x2, in_p_info, in_last_x2, in_last_mem_info, out_ready,
        input  in_ready, out_valid, out_read_num, out_status, out_bi, out_bj, out_new_size,
               out_new_last_size, out_fwd_size, out_mem_wr_addr, out_cur_wr_addr, out_cur_rd_addr,
               out_min_intv, out_iter_bnd, out_c, out_resv_x2, out_resv_mem_info, out_last_one,
               mem_we, mem_addr, mem_x0, mem_x1, mem_x2, mem_info,
               cur_we, cur_addr, cur_x0, cur_x1, cur_x2, cur_info, err_mem_ovf, err_cur_unf
    );

    modport slave (
        input  in_valid, in_status, in_read_num, in_bx, in_c, in_iter_bnd, in_bi, in_bj,
               in_new_size, in_new_last_size, in_fwd_size, in_mem_wr_addr, in_cur_wr_addr,
               in_cur_rd_addr, in_min_intv, in_tok_x0, in_tok_x1, in_tok_x2, in_p_x0, in_p_x1,
               in_p_x2, in_p_info, in_last_x2, in_last_mem_info, out_ready,
        output in_ready, out_valid, out_read_num, out_status, out_bi, out_bj, out_new_size,
               out_new_last_size, out_fwd_size, out_mem_wr_addr, out_cur_wr_addr, out_cur_rd_addr,
               out_min_intv, out_iter_bnd, out_c, out_resv_x2, out_resv_mem_info, out_last_one,
               mem_we, mem_addr, mem_x0, mem_x1, mem_x2, mem_info,
               cur_we, cur_addr, cur_x0, cur_x1, cur_x2, cur_info, err_mem_ovf, err_cur_unf
    );
endinterface

// File: rtl/smem_bck_stage1_ctrl_p.sv
// Stage-1 controller of the SMEM backward extension: per token, emits the parent
// interval to MEM, keeps the extended interval in CURR, and advances read bookkeeping.
module smem_bck_stage1_ctrl_p #(
    parameter int RN_W      = 6,
    parameter int AW        = 7,
    parameter int IW        = 64,
    parameter int MEM_DEPTH = 64,
    parameter int AMB_C     = 4
) (
    input logic                     clk,
    input logic                     rst,
    smem_bck_stage1_ctrl_p_if.slave bus
);
    localparam logic [5:0]    BCK_INI     = 6'b001000;
    localparam logic [5:0]    BCK_RUN     = 6'b010000;
    localparam logic [AW-1:0] ZERO_AW     = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_AW      = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   MEM_DEPTH_L = (AW+1)'(MEM_DEPTH);
    localparam logic [7:0]    AMB_C_L     = 8'(AMB_C);

    typedef struct packed {
        logic [RN_W-1:0] read_num;
        logic [5:0]      status;
        logic [AW-1:0]   bi;
        logic [AW-1:0]   bj;
        logic [AW-1:0]   new_size;
        logic [AW-1:0]   new_last_size;
        logic [AW-1:0]   fwd_size;
        logic [AW-1:0]   mem_wr_addr;
        logic [AW-1:0]   cur_wr_addr;
        logic [AW-1:0]   cur_rd_addr;
        logic [AW-1:0]   min_intv;
        logic            iter_bnd;
        logic [7:0]      c;
        logic [IW-1:0]   resv_x2;
        logic [31:0]     resv_mem_info;
        logic            last_one;
    } bk_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] x0;
        logic [IW-1:0] x1;
        logic [IW-1:0] x2;
        logic [63:0]   info;
    } wr_t;

    bk_t           bk_d_s, bk_r;
    wr_t           mem_d_s, mem_r, cur_d_s, cur_r;
    logic          mem_go_s, cur_go_s, ovf_s, unf_s, acc_s;
    logic          out_valid_r, mem_we_r, cur_we_r, err_mem_ovf_r, err_cur_unf_r;
    logic [AW-1:0] new_i_s, ini_s;
    logic          amb_s, brk_s, c1_s, c2_s, jb_s;

    assign bus.in_ready = !out_valid_r || bus.out_ready;
    assign acc_s        = bus.in_valid && bus.in_ready;

    // brk ends the current extension; c1 and c2 cannot both hold because one needs brk, the other !brk.
    assign new_i_s = bus.in_iter_bnd ? ZERO_AW : bus.in_bi + ONE_AW;
    assign ini_s   = bus.in_fwd_size - ONE_AW;
    assign amb_s   = bus.in_c >= AMB_C_L;
    assign brk_s   = amb_s || bus.in_iter_bnd || (bus.in_tok_x2 < IW'(bus.in_min_intv));
    assign c1_s    = brk_s && (bus.in_new_size == ZERO_AW) &&
                     ((bus.in_mem_wr_addr == ZERO_AW) || (new_i_s < bus.in_last_mem_info[AW-1:0]));
    assign c2_s    = !brk_s && ((bus.in_new_size == ZERO_AW) || (bus.in_tok_x2 != bus.in_last_x2));
    assign jb_s    = bus.in_bj == (bus.in_new_last_size - ONE_AW);

    // Next bookkeeping and store requests for the presented token.
    always_comb begin
        bk_d_s   = '0;
        mem_d_s  = '0;
        cur_d_s  = '0;
        mem_go_s = 1'b0;
        cur_go_s = 1'b0;
        ovf_s    = 1'b0;
        unf_s    = 1'b0;
        case (bus.in_status)
            BCK_INI: begin
                bk_d_s.read_num      = bus.in_read_num;
                bk_d_s.status        = BCK_INI;
                bk_d_s.min_intv      = bus.in_min_intv;
                bk_d_s.cur_rd_addr   = ini_s;
                bk_d_s.cur_wr_addr   = ini_s;
                bk_d_s.new_last_size = bus.in_fwd_size;
                bk_d_s.fwd_size      = bus.in_fwd_size;
                if (bus.in_bx == ZERO_AW) begin
                    bk_d_s.iter_bnd = 1'b1;
                end else begin
                    bk_d_s.bi = bus.in_bx - ONE_AW;
                    bk_d_s.c  = 8'(bus.in_bx - ONE_AW);
                end
            end
            BCK_RUN: begin
                bk_d_s.read_num      = bus.in_read_num;
                bk_d_s.status        = BCK_RUN;
                bk_d_s.bi            = bus.in_bi;
                bk_d_s.bj            = bus.in_bj;
                bk_d_s.new_last_size = bus.in_new_last_size;
                bk_d_s.fwd_size      = bus.in_fwd_size;
                bk_d_s.min_intv      = bus.in_min_intv;
                bk_d_s.iter_bnd      = bus.in_iter_bnd;
                bk_d_s.c             = 8'(bus.in_bi);
                bk_d_s.cur_rd_addr   = jb_s ? ini_s : bus.in_cur_rd_addr - ONE_AW;
                bk_d_s.mem_wr_addr   = bus.in_mem_wr_addr;
                bk_d_s.cur_wr_addr   = bus.in_cur_wr_addr;
                bk_d_s.new_size      = bus.in_new_size;
                bk_d_s.resv_x2       = bus.in_last_x2;
                bk_d_s.resv_mem_info = bus.in_last_mem_info;
                bk_d_s.last_one      = (bus.in_new_size == ZERO_AW) && c2_s && jb_s;
                mem_d_s = '{addr: bus.in_mem_wr_addr, x0: bus.in_p_x0, x1: bus.in_p_x1,
                            x2: bus.in_p_x2, info: {32'(new_i_s), bus.in_p_info[31:0]}};
                cur_d_s = '{addr: bus.in_cur_wr_addr, x0: bus.in_tok_x0, x1: bus.in_tok_x1,
                            x2: bus.in_tok_x2, info: bus.in_p_info};
                if (c1_s) begin
                    bk_d_s.resv_mem_info = 32'(new_i_s);
                    // A full MEM buffer drops the write but keeps the pointer so later tokens see the same state.
                    if ({1'b0, bus.in_mem_wr_addr} >= MEM_DEPTH_L) begin
                        ovf_s = 1'b1;
                    end else begin
                        mem_go_s           = 1'b1;
                        bk_d_s.mem_wr_addr = bus.in_mem_wr_addr + ONE_AW;
                    end
                end else begin
                    mem_go_s = 1'b0;
                end
                if (c2_s) begin
                    cur_go_s         = 1'b1;
                    bk_d_s.new_size  = bus.in_new_size + ONE_AW;
                    bk_d_s.resv_x2   = bus.in_tok_x2;
                    // CURR grows downward; at address 0 the write lands and the pointer saturates.
                    if (bus.in_cur_wr_addr == ZERO_AW) begin
                        unf_s = 1'b1;
                    end else begin
                        bk_d_s.cur_wr_addr = bus.in_cur_wr_addr - ONE_AW;
                    end
                end else begin
                    cur_go_s = 1'b0;
                end
            end
            default: begin
                bk_d_s = '0;
            end
        endcase
    end

    // Output register: load on acceptance, drain on downstream ready, store pulses last one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bk_r          <= '0;
            mem_r         <= '0;
            cur_r         <= '0;
            out_valid_r   <= 1'b0;
            mem_we_r      <= 1'b0;
            cur_we_r      <= 1'b0;
            err_mem_ovf_r <= 1'b0;
            err_cur_unf_r <= 1'b0;
        end else begin
            mem_we_r <= acc_s && mem_go_s;
            cur_we_r <= acc_s && cur_go_s;
            if (acc_s) begin
                out_valid_r   <= 1'b1;
                bk_r          <= bk_d_s;
                err_mem_ovf_r <= err_mem_ovf_r || ovf_s;
                err_cur_unf_r <= err_cur_unf_r || unf_s;
                if (mem_go_s) begin
                    mem_r <= mem_d_s;
                end
                if (cur_go_s) begin
                    cur_r <= cur_d_s;
                end
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid         = out_valid_r;
    assign bus.out_read_num      = bk_r.read_num;
    assign bus.out_status        = bk_r.status;
    assign bus.out_bi            = bk_r.bi;
    assign bus.out_bj            = bk_r.bj;
    assign bus.out_new_size      = bk_r.new_size;
    assign bus.out_new_last_size = bk_r.new_last_size;
    assign bus.out_fwd_size      = bk_r.fwd_size;
    assign bus.out_mem_wr_addr   = bk_r.mem_wr_addr;
    assign bus.out_cur_wr_addr   = bk_r.cur_wr_addr;
    assign bus.out_cur_rd_addr   = bk_r.cur_rd_addr;
    assign bus.out_min_intv      = bk_r.min_intv;
    assign bus.out_iter_bnd      = bk_r.iter_bnd;
    assign bus.out_c             = bk_r.c;
    assign bus.out_resv_x2       = bk_r.resv_x2;
    assign bus.out_resv_mem_info = bk_r.resv_mem_info;
    assign bus.out_last_one      = bk_r.last_one;
    assign bus.mem_we            = mem_we_r;
    assign bus.mem_addr          = mem_r.addr;
    assign bus.mem_x0            = mem_r.x0;
    assign bus.mem_x1            = mem_r.x1;
    assign bus.mem_x2            = mem_r.x2;
    assign bus.mem_info          = mem_r.info;
    assign bus.cur_we            = cur_we_r;
    assign bus.cur_addr          = cur_r.addr;
    assign bus.cur_x0            = cur_r.x0;
    assign bus.cur_x1            = cur_r.x1;
    assign bus.cur_x2            = cur_r.x2;
    assign bus.cur_info          = cur_r.info;
    assign bus.err_mem_ovf       = err_mem_ovf_r;
    assign bus.err_cur_unf       = err_cur_unf_r;
endmodule

// File: tb/tb_smem_bck_stage1_ctrl_p.sv
// Directed and random tokens against an arithmetic reference model of the stage-1 controller.
module tb_smem_bck_stage1_ctrl_p;
    localparam int RN_W = 6, AW = 7, IW = 64, MEM_DEPTH = 64, AMB_C = 4;
    localparam int AM = 1 << AW;
    localparam int ST_INI = 8, ST_RUN = 16;

    typedef struct {
        int status, rn, bx, c, ib, bi, bj, ns, nls, fs, mwa, cwa, cra, mi;
        logic [63:0] x0, x1, x2, p0, p1, p2, pinfo, lx2;
        logic [31:0] lmi;
    } tok_t;

    typedef struct {
        int status, rn, bi, bj, ns, nls, fs, mwa, cwa, cra, mi, ib, c, last_one;
        logic [63:0] rx2, minfo;
        logic [31:0] rmi;
        bit mem_go, cur_go, ovf, unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_valid = 1'b0, m_mem_we = 1'b0, m_cur_we = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    exp_t m_e;
    tok_t m_t;

    always #5 clk = ~clk;

    smem_bck_stage1_ctrl_p_if #(.RN_W(RN_W), .AW(AW), .IW(IW)) bus ();

    smem_bck_stage1_ctrl_p #(.RN_W(RN_W), .AW(AW), .IW(IW), .MEM_DEPTH(MEM_DEPTH), .AMB_C(AMB_C))
        dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: straight from the token rules, modular arithmetic on plain ints.
    function automatic exp_t model(input tok_t t);
        exp_t e;
        int new_i, ini;
        bit brk, c1, c2, jb;
        e = '{default: 0};
        new_i = (t.ib != 0) ? 0 : (t.bi + 1) % AM;
        ini   = (t.fs + AM - 1) % AM;
        brk   = (t.c >= AMB_C) || (t.ib != 0) || (t.x2 < 64'(t.mi));
        c1    = brk && t.ns == 0 && (t.mwa == 0 || new_i < int'(t.lmi % AM));
        c2    = !brk && (t.ns == 0 || t.x2 != t.lx2);
        jb    = t.bj == (t.nls + AM - 1) % AM;
        if (t.status == ST_INI) begin
            e.status = ST_INI; e.rn = t.rn; e.mi = t.mi;
            e.cra = ini; e.cwa = ini; e.nls = t.fs; e.fs = t.fs;
            if (t.bx == 0) e.ib = 1;
            else begin e.bi = t.bx - 1; e.c = t.bx - 1; end
        end else if (t.status == ST_RUN) begin
            e.status = ST_RUN; e.rn = t.rn; e.bi = t.bi; e.bj = t.bj; e.nls = t.nls;
            e.fs = t.fs; e.mi = t.mi; e.ib = t.ib; e.c = t.bi;
            e.cra = jb ? ini : (t.cra + AM - 1) % AM;
            e.mwa = t.mwa; e.cwa = t.cwa; e.ns = t.ns; e.rx2 = t.lx2; e.rmi = t.lmi;
            e.minfo = {32'(new_i), t.pinfo[31:0]};
            if (c1) begin
                e.rmi = 32'(new_i);
                if (t.mwa >= MEM_DEPTH) e.ovf = 1'b1;
                else begin e.mem_go = 1'b1; e.mwa = t.mwa + 1; end
            end
            if (c2) begin
                e.cur_go = 1'b1; e.ns = (t.ns + 1) % AM; e.rx2 = t.x2;
                if (t.cwa == 0) e.unf = 1'b1;
                else e.cwa = t.cwa - 1;
            end
            e.last_one = (t.ns == 0 && c2 && jb) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic tok_t base_tok();
        tok_t t;
        t = '{default: 0};
        t.status = ST_RUN; t.fs = 10; t.nls = 10; t.bj = 3; t.cra = 5; t.cwa = 9; t.mwa = 2;
        t.mi = 5; t.x2 = 64'd20; t.lx2 = 64'd7; t.c = 1; t.bi = 3; t.lmi = 32'd100;
        t.x0 = 64'h1111_0000_0000_00a0; t.x1 = 64'h2222_0000_0000_00b0;
        t.p0 = 64'h3333_0000_0000_00c0; t.p1 = 64'h4444_0000_0000_00d0;
        t.p2 = 64'h5555_0000_0000_00e0; t.pinfo = 64'hdead_beef_cafe_f00d; t.rn = 17;
        return t;
    endfunction

    function automatic tok_t rand_tok();
        tok_t t;
        int s;
        s = $urandom_range(0, 19);
        t.status = (s < 4) ? ST_INI : ((s < 17) ? ST_RUN : int'($urandom_range(0, 63)));
        t.rn   = $urandom_range(0, 63);
        t.bx   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.c    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
        t.ib   = ($urandom_range(0, 7) == 0) ? 1 : 0;
        t.bi   = ($urandom_range(0, 7) == 0) ? AM - 1 : $urandom_range(0, AM - 1);
        t.nls  = $urandom_range(0, AM - 1);
        t.bj   = ($urandom_range(0, 1) == 0) ? (t.nls + AM - 1) % AM : $urandom_range(0, AM - 1);
        t.ns   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.fs   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.mwa  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.cwa  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.cra  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, AM - 1);
        t.mi   = $urandom_range(0, 20);
        t.x2   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
        t.lx2  = ($urandom_range(0, 2) == 0) ? t.x2 : 64'($urandom_range(0, 40));
        t.lmi  = $urandom;
        t.x0   = {$urandom, $urandom}; t.x1 = {$urandom, $urandom};
        t.p0   = {$urandom, $urandom}; t.p1 = {$urandom, $urandom}; t.p2 = {$urandom, $urandom};
        t.pinfo = {$urandom, $urandom};
        return t;
    endfunction

    task automatic drive(input tok_t t);
        bus.in_status = 6'(t.status); bus.in_read_num = RN_W'(t.rn); bus.in_bx = AW'(t.bx);
        bus.in_c = 8'(t.c); bus.in_iter_bnd = (t.ib != 0); bus.in_bi = AW'(t.bi);
        bus.in_bj = AW'(t.bj); bus.in_new_size = AW'(t.ns); bus.in_new_last_size = AW'(t.nls);
        bus.in_fwd_size = AW'(t.fs); bus.in_mem_wr_addr = AW'(t.mwa);
        bus.in_cur_wr_addr = AW'(t.cwa); bus.in_cur_rd_addr = AW'(t.cra);
        bus.in_min_intv = AW'(t.mi); bus.in_tok_x0 = t.x0; bus.in_tok_x1 = t.x1;
        bus.in_tok_x2 = t.x2; bus.in_p_x0 = t.p0; bus.in_p_x1 = t.p1; bus.in_p_x2 = t.p2;
        bus.in_p_info = t.pinfo; bus.in_last_x2 = t.lx2; bus.in_last_mem_info = t.lmi;
    endtask

    task automatic compare_all();
        check_val("out_valid", bus.out_valid, m_valid);
        check_val("mem_we", bus.mem_we, m_mem_we);
        check_val("cur_we", bus.cur_we, m_cur_we);
        check_val("err_mem_ovf", bus.err_mem_ovf, m_ovf);
        check_val("err_cur_unf", bus.err_cur_unf, m_unf);
        check_val("read_num", bus.out_read_num, m_e.rn);
        check_val("status", bus.out_status, m_e.status);
        check_val("bi", bus.out_bi, m_e.bi);
        check_val("bj", bus.out_bj, m_e.bj);
        check_val("new_size", bus.out_new_size, m_e.ns);
        check_val("new_last_size", bus.out_new_last_size, m_e.nls);
        check_val("fwd_size", bus.out_fwd_size, m_e.fs);
        check_val("mem_wr_addr", bus.out_mem_wr_addr, m_e.mwa);
        check_val("cur_wr_addr", bus.out_cur_wr_addr, m_e.cwa);
        check_val("cur_rd_addr", bus.out_cur_rd_addr, m_e.cra);
        check_val("min_intv", bus.out_min_intv, m_e.mi);
        check_val("iter_bnd", bus.out_iter_bnd, m_e.ib);
        check_val("c", bus.out_c, m_e.c);
        check_val("resv_x2", bus.out_resv_x2, m_e.rx2);
        check_val("resv_mem_info", bus.out_resv_mem_info, m_e.rmi);
        check_val("last_one", bus.out_last_one, m_e.last_one);
        if (m_mem_we) begin
            check_val("mem_addr", bus.mem_addr, m_t.mwa);
            check_val("mem_x0", bus.mem_x0, m_t.p0);
            check_val("mem_x1", bus.mem_x1, m_t.p1);
            check_val("mem_x2", bus.mem_x2, m_t.p2);
            check_val("mem_info", bus.mem_info, m_e.minfo);
        end
        if (m_cur_we) begin
            check_val("cur_addr", bus.cur_addr, m_t.cwa);
            check_val("cur_x0", bus.cur_x0, m_t.x0);
            check_val("cur_x1", bus.cur_x1, m_t.x1);
            check_val("cur_x2", bus.cur_x2, m_t.x2);
            check_val("cur_info", bus.cur_info, m_t.pinfo);
        end
    endtask

    // One clock: drive at negedge, check ready, advance the model, check outputs after the edge.
    task automatic step(input bit v, input bit r, input bit rs, input tok_t t);
        bit   acc;
        exp_t e;
        @(negedge clk);
        rst = rs;
        drive(t);
        bus.in_valid = v;
        bus.out_ready = r;
        #1;
        check_val("in_ready", bus.in_ready, (!m_valid || r));
        acc = v && (!m_valid || r);
        e = model(t);
        @(posedge clk);
        #1;
        if (!rs) begin
            m_valid = 1'b0; m_mem_we = 1'b0; m_cur_we = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_e = '{default: 0};
        end else if (acc) begin
            m_valid = 1'b1; m_e = e; m_t = t;
            m_mem_we = e.mem_go; m_cur_we = e.cur_go;
            m_ovf = m_ovf || e.ovf; m_unf = m_unf || e.unf;
        end else begin
            m_mem_we = 1'b0; m_cur_we = 1'b0;
            if (r) m_valid = 1'b0;
        end
        compare_all();
    endtask

    initial begin
        tok_t t;
        m_e = '{default: 0};
        m_t = '{default: 0};
        drive(base_tok());
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b1, 1'b0, base_tok());

        t = base_tok(); t.status = ST_INI; t.bx = 0; t.fs = 10;
        step(1'b1, 1'b1, 1'b1, t);
        t = base_tok(); t.bx = 37; t.status = ST_INI;
        step(1'b1, 1'b1, 1'b1, t);
        t = base_tok(); t.c = 2; t.x2 = 64'd20; t.mi = 5; t.ns = 0; t.cwa = 9;
        step(1'b1, 1'b1, 1'b1, t);
        t = base_tok(); t.c = 4; t.ns = 0; t.mwa = 0; t.bi = 3;
        step(1'b1, 1'b1, 1'b1, t);
        t.mwa = MEM_DEPTH;
        step(1'b1, 1'b1, 1'b1, t);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, base_tok());
        t = base_tok(); t.c = 2; t.ns = 0; t.cwa = 0;
        step(1'b1, 1'b1, 1'b1, t);

        t = base_tok(); t.c = 2; t.ns = 0; t.cwa = 12;
        step(1'b1, 1'b0, 1'b1, t);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, rand_tok());
        step(1'b0, 1'b1, 1'b1, base_tok());
        t = base_tok(); t.nls = 10; t.bj = 9; t.ns = 0; t.fs = 10; t.cra = 3;
        step(1'b1, 1'b1, 1'b1, t);
        t = base_tok(); t.status = 6'b000001;
        step(1'b1, 1'b1, 1'b1, t);

        step(1'b1, 1'b0, 1'b1, base_tok());
        step(1'b1, 1'b0, 1'b0, base_tok());

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) != 0, rand_tok());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
